// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI command-stream frame link.
// Used by spi_frame_tx (SPI_FRAME_TX_ABORT_EN adds the abort port) and by the receiver bench.
package spi_frame_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned HP_W   = 5;   // counts the 32 SCK half-periods of one word

  localparam logic [1:0] CMD_DATA    = 2'd1;
  localparam logic [1:0] CMD_CONTROL = 2'd2;
  localparam logic [1:0] CMD_DONE    = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    FETCH,
    HOLD
  } state_e;

endpackage

// File: rtl/spi_word_shifter.sv
// 16-bit MSB-first shift register with SCK divider and half-period counter.
// The frame FSM in spi_frame_tx sequences it.
module spi_word_shifter
  import spi_frame_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              enter,
  input  logic              shift_start,
  input  logic              shifting,
  output logic              sck,
  output logic              mosi,
  output logic              div_tc_c,
  output logic              word_last_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]  div_cnt;
  logic [HP_W-1:0]   hp_cnt;
  logic [WORD_W-1:0] sreg;

  assign div_tc_c    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign word_last_c = shifting && div_tc_c && (hp_cnt == HP_W'(2 * WORD_W - 1));
  assign mosi        = sreg[WORD_W-1];

  // Even half-periods are SCK high; data advances when SCK falls, except after bit0.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      div_cnt <= '0;
      hp_cnt  <= '0;
      sreg    <= '0;
      sck     <= 1'b0;
    end else begin
      div_cnt <= (enter || div_tc_c) ? '0 : div_cnt + DIV_W'(1);
      if (clear) begin
        sck    <= 1'b0;
        hp_cnt <= '0;
      end else if (shift_start) begin
        sck    <= 1'b1;
        hp_cnt <= '0;
      end else if (shifting && div_tc_c && !word_last_c) begin
        sck    <= ~sck;
        hp_cnt <= hp_cnt + HP_W'(1);
        if (sck && (hp_cnt != HP_W'(2 * WORD_W - 2))) begin
          sreg <= {sreg[WORD_W-2:0], 1'b0};
        end
      end
      if (load) begin
        sreg <= load_data;
      end
    end
  end

endmodule

// File: rtl/spi_frame_tx.sv
// SPI mode-0 frame initiator: command word then n_words payload words, MSB first.
// Define SPI_FRAME_TX_ABORT_EN to add an abort input that drops CS_n without completing the frame.
module spi_frame_tx
  import spi_frame_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned LEN_W   = 8
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [LEN_W-1:0]  n_words,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
`ifdef SPI_FRAME_TX_ABORT_EN
  input  logic              abort,
`endif
  output logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic              spi_cs_n
);

  state_e            state, state_d;
  logic [LEN_W-1:0]  remaining, remaining_d;
  logic              load;
  logic [WORD_W-1:0] load_data;
  logic              done_d;
  logic              div_tc_c;
  logic              word_last_c;

  spi_word_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk         (clk),
    .nRst        (nRst),
    .clear       (state_d == IDLE),
    .load        (load),
    .load_data   (load_data),
    .enter       (state_d != state),
    .shift_start ((state == SETUP) && (state_d == SHIFT)),
    .shifting    (state == SHIFT),
    .sck         (spi_sck),
    .mosi        (spi_mosi),
    .div_tc_c    (div_tc_c),
    .word_last_c (word_last_c)
  );

  // Frame sequencing and payload handshake.
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    load        = 1'b0;
    load_data   = {{(WORD_W-2){1'b0}}, cmd};
    done_d      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d     = SETUP;
          remaining_d = n_words;
          load        = 1'b1;
        end
      end
      SETUP: begin
        if (div_tc_c) state_d = SHIFT;
      end
      SHIFT: begin
        if (word_last_c) state_d = (remaining != '0) ? FETCH : HOLD;
      end
      FETCH: begin
        if (word_valid) begin
          state_d     = SETUP;
          remaining_d = remaining - LEN_W'(1);
          load        = 1'b1;
          load_data   = word_in;
        end
      end
      HOLD: begin
        if (div_tc_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SPI_FRAME_TX_ABORT_EN
    if (abort && (state != IDLE)) begin
      state_d = IDLE;
      load    = 1'b0;
      done_d  = 1'b0;
    end
`endif
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state      <= IDLE;
      remaining  <= '0;
      spi_cs_n   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_ready <= 1'b0;
    end else begin
      state      <= state_d;
      remaining  <= remaining_d;
      spi_cs_n   <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      done       <= done_d;
      word_ready <= (state_d == FETCH);
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx with an SPI receiver model sampling MOSI on SCK rise.
// Build with SPI_FRAME_TX_ABORT_EN to also exercise the abort port.
module tb_spi_frame_tx;
  import spi_frame_pkg::*;

  logic        clk = 1'b0;
  logic        nRst;
  logic        start;
  logic [1:0]  cmd;
  logic [7:0]  n_words;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic        done;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_cs_n;
`ifdef SPI_FRAME_TX_ABORT_EN
  logic        abort;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_frame_tx #(
    .CLK_DIV (2),
    .LEN_W   (8)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .start      (start),
    .cmd        (cmd),
    .n_words    (n_words),
    .word_in    (word_in),
    .word_valid (word_valid),
`ifdef SPI_FRAME_TX_ABORT_EN
    .abort      (abort),
`endif
    .word_ready (word_ready),
    .busy       (busy),
    .done       (done),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n)
  );

  // Receiver model: assembles 16-bit words while CS_n is low, decodes CONTROL stop bit.
  int          rises      = 0;
  int          rise_cs_hi = 0;
  int          mosi_viol  = 0;
  int          done_cnt   = 0;
  int          busy_cyc   = 0;
  int          rx_n       = 0;
  int          bits       = 0;
  int          wcnt       = 0;
  logic [15:0] sh         = '0;
  logic [15:0] rx_mem [64];
  logic [1:0]  cmd_seen   = '0;
  logic        stop_game  = 1'b0;
  logic        prev_sck   = 1'b0;
  logic        prev_mosi  = 1'b0;

  always @(negedge clk) begin
    if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
      if (spi_cs_n !== 1'b0) begin
        rise_cs_hi++;
      end else begin
        rises++;
        sh = {sh[14:0], spi_mosi};
        bits++;
        if (bits == 16) begin
          rx_mem[rx_n % 64] = sh;
          rx_n++;
          if (wcnt == 0) cmd_seen = sh[1:0];
          else if (wcnt == 1 && cmd_seen == CMD_CONTROL) stop_game = sh[0];
          wcnt++;
          bits = 0;
        end
      end
    end
    if (spi_sck === 1'b1 && spi_mosi !== prev_mosi) mosi_viol++;
    if (spi_cs_n !== 1'b0) begin
      bits = 0;
      wcnt = 0;
    end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cyc++;
    prev_sck  = spi_sck;
    prev_mosi = spi_mosi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One frame: optional stall on the first payload word, optional ignored start pulse.
  task automatic run_frame(input logic [1:0] c, input int n, input logic [15:0] w0,
                           input logic [15:0] w1, input int stall, input bit poke,
                           input int exp_cyc, input string tag);
    int r0, d0, b0, h0, k;
    bit seen;
    r0 = rises; d0 = done_cnt; b0 = busy_cyc; h0 = rise_cs_hi;
    @(negedge clk);
    cmd = c; n_words = 8'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (30) @(negedge clk);
      cmd = CMD_DATA; n_words = 8'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      word_in    = (i == 0) ? w0 : w1;
      word_valid = !(i == 0 && stall > 0);
      k = 0;
      while (word_ready !== 1'b1 && k < 400) begin
        @(negedge clk);
        k++;
      end
      check({tag, "_fetch_wait"}, 32'(word_ready), 32'd1);
      if (i == 0 && stall > 0) begin
        for (int j = 0; j < stall; j++) begin
          @(negedge clk);
          check({tag, "_stall_sck_cs_rdy"}, 32'({spi_sck, spi_cs_n, word_ready}), 32'b001);
        end
        word_valid = 1'b1;
      end
      @(negedge clk);
      word_valid = 1'b0;
    end
    seen = 1'b0;
    k = 0;
    while (!seen && k < 600) begin
      @(negedge clk);
      k++;
      seen = (done === 1'b1);
    end
    #1;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_cs_high"}, 32'(spi_cs_n), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cyc - b0), 32'(exp_cyc));
    check({tag, "_sck_rises"}, 32'(rises - r0), 32'(16 * (n + 1)));
    check({tag, "_rises_cs_high"}, 32'(rise_cs_hi - h0), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int base, k;
    nRst = 1'b0; start = 1'b0; cmd = '0; n_words = '0; word_in = '0; word_valid = 1'b0;
`ifdef SPI_FRAME_TX_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_word_ready", 32'(word_ready), 32'd0);
    nRst = 1'b1;
    @(negedge clk);
    check("idle_cs_n", 32'(spi_cs_n), 32'd1);

    // DATA frame, payload always valid
    base = rx_n;
    run_frame(CMD_DATA, 2, 16'h0ABC, 16'h1FFF, 0, 1'b0, 202, "data");
    check("data_nwords", 32'(rx_n - base), 32'd3);
    check("data_w0", 32'(rx_mem[base % 64]), 32'h0001);
    check("data_w1", 32'(rx_mem[(base + 1) % 64]), 32'h0ABC);
    check("data_w2", 32'(rx_mem[(base + 2) % 64]), 32'h1FFF);
    check("data_no_stop", 32'(stop_game), 32'd0);

    // CONTROL frame with stop bit set
    base = rx_n;
    run_frame(CMD_CONTROL, 1, 16'h0001, 16'h0000, 0, 1'b0, 135, "ctrl");
    check("ctrl_nwords", 32'(rx_n - base), 32'd2);
    check("ctrl_w0", 32'(rx_mem[base % 64]), 32'h0002);
    check("ctrl_w1", 32'(rx_mem[(base + 1) % 64]), 32'h0001);
    check("ctrl_stop_game", 32'(stop_game), 32'd1);

    // Same DATA frame with a 20-cycle stall in FETCH
    base = rx_n;
    run_frame(CMD_DATA, 2, 16'h0ABC, 16'h1FFF, 20, 1'b0, 222, "stall");
    check("stall_nwords", 32'(rx_n - base), 32'd3);
    check("stall_w0", 32'(rx_mem[base % 64]), 32'h0001);
    check("stall_w1", 32'(rx_mem[(base + 1) % 64]), 32'h0ABC);
    check("stall_w2", 32'(rx_mem[(base + 2) % 64]), 32'h1FFF);

    // DONE frame, start pulsed mid-shift must be ignored
    base = rx_n;
    run_frame(CMD_DONE, 0, 16'h0000, 16'h0000, 0, 1'b1, 68, "done");
    check("done_nwords", 32'(rx_n - base), 32'd1);
    check("done_w0", 32'(rx_mem[base % 64]), 32'h0003);

    // Reset in the middle of the second word
    base = rx_n;
    @(negedge clk);
    cmd = CMD_DATA; n_words = 8'd2; word_in = 16'h0ABC; word_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (rx_n < base + 1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("midrst_first_word", 32'(rx_n - base), 32'd1);
    repeat (20) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    nRst = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", 32'(spi_cs_n), 32'd1);
    check("midrst_sck", 32'(spi_sck), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_word_ready", 32'(word_ready), 32'd0);
    nRst = 1'b1;
    word_valid = 1'b0;
    @(negedge clk);
    base = rx_n;
    run_frame(CMD_DONE, 0, 16'h0000, 16'h0000, 0, 1'b0, 68, "after_rst");
    check("after_rst_nwords", 32'(rx_n - base), 32'd1);
    check("after_rst_w0", 32'(rx_mem[base % 64]), 32'h0003);

`ifdef SPI_FRAME_TX_ABORT_EN
    base = rx_n;
    k = done_cnt;
    @(negedge clk);
    cmd = CMD_DONE; n_words = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_sck", 32'(spi_sck), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_word", 32'(rx_n - base), 32'd0);
    check("abort_no_done", 32'(done_cnt - k), 32'd0);
`endif

    check("mosi_stable_while_sck_high", 32'(mosi_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
